// File: rtl/cl_ocl_bar1_reg_arb_if.sv
// Dual-port AXI-Lite slave bundle for the OCL (index 0) and BAR1 (index 1) host paths.
// Every per-port vector packs port 0 in the low slice and port 1 in the high slice.
//   master : host side (drives valid/addr/data and B/R ready)
//   slave  : arbiter side (drives AW/W/AR ready and the B/R responses)
interface cl_ocl_bar1_reg_arb_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [1:0]          s_awvalid;
  logic [2*ADDR_W-1:0] s_awaddr;
  logic [1:0]          s_awready;
  logic [1:0]          s_wvalid;
  logic [63:0]         s_wdata;
  logic [7:0]          s_wstrb;
  logic [1:0]          s_wready;
  logic [1:0]          s_bvalid;
  logic [3:0]          s_bresp;
  logic [1:0]          s_bready;
  logic [1:0]          s_arvalid;
  logic [2*ADDR_W-1:0] s_araddr;
  logic [1:0]          s_arready;
  logic [1:0]          s_rvalid;
  logic [63:0]         s_rdata;
  logic [3:0]          s_rresp;
  logic [1:0]          s_rready;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/cl_ocl_bar1_reg_arb.sv
// Shares one CL register bus between the OCL (port 0) and BAR1 (port 1) AXI-Lite slave paths.
// Round-robin arbitration with a single transaction in flight; every access completes on
// the AXI side, either with the register file's ack or with a timeout error.
// Ports:
//   clk_main_a0, rst_main : clock, synchronous active-high reset
//   s                     : dual-port AXI-Lite slave bundle (see cl_ocl_bar1_reg_arb_if)
//   reg_req/reg_wr/reg_addr/reg_wdata/reg_wstrb : register bus request (addr/data held REQ..RESP)
//   reg_ack/reg_rdata     : register bus completion
//   busy, grant_id, tmo_cnt : status (not idle, current/last owner, saturating timeout count)
module cl_ocl_bar1_reg_arb #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main,
  cl_ocl_bar1_reg_arb_if.slave   s,
  output logic                   reg_req,
  output logic                   reg_wr,
  output logic [ADDR_W-1:0]      reg_addr,
  output logic [31:0]            reg_wdata,
  output logic [3:0]             reg_wstrb,
  input  logic                   reg_ack,
  input  logic [31:0]            reg_rdata,
  output logic                   busy,
  output logic                   grant_id,
  output logic [15:0]            tmo_cnt
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccept = 3'd1;
  localparam logic [2:0] StReq    = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  // Port that wins a tie at the next grant; separate from gnt_q so that reset can leave
  // grant_id at 0 while still giving port 0 first priority.
  logic              prio_q, prio_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [15:0]       tmo_q, tmo_d;

  logic [1:0] pend;
  logic       sel;
  logic       resp_taken;

  // A port needs both AW and W before its write counts as pending.
  assign pend = (s.s_awvalid & s.s_wvalid) | s.s_arvalid;
  assign sel  = pend[prio_q] ? prio_q : ~prio_q;

  assign resp_taken = wr_q ? s.s_bready[gnt_q] : s.s_rready[gnt_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (|pend) begin
          gnt_d   = sel;
          prio_d  = ~sel;
          wr_d    = s.s_awvalid[sel] & s.s_wvalid[sel];
          state_d = StAccept;
        end
      end
      StAccept: begin
        if (wr_q) begin
          addr_d  = gnt_q ? s.s_awaddr[2*ADDR_W-1:ADDR_W] : s.s_awaddr[ADDR_W-1:0];
          wdata_d = gnt_q ? s.s_wdata[63:32] : s.s_wdata[31:0];
          wstrb_d = gnt_q ? s.s_wstrb[7:4] : s.s_wstrb[3:0];
        end else begin
          addr_d  = gnt_q ? s.s_araddr[2*ADDR_W-1:ADDR_W] : s.s_araddr[ADDR_W-1:0];
        end
        state_d = StReq;
      end
      StReq: begin
        tcnt_d = '0;
        if (reg_ack) begin
          resp_d  = 2'b00;
          rdata_d = reg_rdata;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (reg_ack) begin
          resp_d  = 2'b00;
          rdata_d = reg_rdata;
          state_d = StResp;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          // TIMEOUT_CYC-th WAIT cycle without an ack.
          resp_d  = 2'b10;
          rdata_d = ERR_RDATA;
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          state_d = StResp;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_taken) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      tcnt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // AXI-side outputs decode straight from state; the non-granted port sees all zeros.
  always_comb begin
    s.s_awready = 2'b00;
    s.s_wready  = 2'b00;
    s.s_arready = 2'b00;
    s.s_bvalid  = 2'b00;
    s.s_rvalid  = 2'b00;
    s.s_bresp   = 4'h0;
    s.s_rresp   = 4'h0;
    s.s_rdata   = 64'h0;
    if (state_q == StAccept) begin
      if (wr_q) begin
        s.s_awready[gnt_q] = 1'b1;
        s.s_wready[gnt_q]  = 1'b1;
      end else begin
        s.s_arready[gnt_q] = 1'b1;
      end
    end
    if (state_q == StResp) begin
      if (wr_q) begin
        s.s_bvalid[gnt_q] = 1'b1;
        s.s_bresp         = gnt_q ? {resp_q, 2'b00} : {2'b00, resp_q};
      end else begin
        s.s_rvalid[gnt_q] = 1'b1;
        s.s_rresp         = gnt_q ? {resp_q, 2'b00} : {2'b00, resp_q};
        s.s_rdata         = gnt_q ? {rdata_q, 32'h0} : {32'h0, rdata_q};
      end
    end
  end

  assign reg_req   = (state_q == StReq);
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wstrb = wstrb_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = gnt_q;
  assign tmo_cnt   = tmo_q;

endmodule

// File: tb/tb_cl_ocl_bar1_reg_arb.sv
// Scoreboard bench for cl_ocl_bar1_reg_arb: stimulus pushes expected register accesses and
// AXI responses into queues; monitors pop and compare as the DUT presents them.
module tb_cl_ocl_bar1_reg_arb;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_exp_t;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_req, reg_wr, reg_ack, busy, grant_id;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic [15:0] tmo_cnt;

  reg_exp_t eq[$];
  rsp_exp_t rq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc = 0;
  int resp_cyc = 0;
  int ack_dly = 0;

  cl_ocl_bar1_reg_arb_if #(.ADDR_W(32)) ifc ();

  cl_ocl_bar1_reg_arb #(
    .ADDR_W(32),
    .TIMEOUT_CYC(TMO),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_main_a0(clk),
    .rst_main(rst),
    .s(ifc),
    .reg_req(reg_req),
    .reg_wr(reg_wr),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack),
    .reg_rdata(reg_rdata),
    .busy(busy),
    .grant_id(grant_id),
    .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {27'h0, ifc.s_awready, ifc.s_wready, ifc.s_bvalid, ifc.s_bresp, ifc.s_arready,
             ifc.s_rvalid, ifc.s_rresp, reg_req, busy, grant_id, tmo_cnt}, 64'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register-file model: checks each strobe and acks after ack_dly cycles (never if < 0).
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reg_req && !rst) begin
        req_cyc = cyc;
        if (eq.size() == 0) begin
          chk("unexpected_reg_req", {31'h0, reg_wr, reg_addr}, 64'h0);
        end else begin
          reg_exp_t e;
          e = eq.pop_front();
          chk("reg_wr", {63'h0, reg_wr}, {63'h0, e.wr});
          chk("reg_addr", {32'h0, reg_addr}, {32'h0, e.addr});
          if (e.wr) chk("reg_wdata_strb", {28'h0, reg_wstrb, reg_wdata}, {28'h0, e.wstrb, e.wdata});
        end
        if (ack_dly >= 0) begin
          repeat (ack_dly) @(negedge clk);
          reg_ack   = 1'b1;
          reg_rdata = 32'hC0DE_0000 | {16'h0, reg_addr[15:0]};
          @(negedge clk);
          reg_ack   = 1'b0;
        end
      end
    end
  end

  task automatic take_rsp(input int p, input logic wr, input logic [1:0] resp,
                          input logic [31:0] data);
    resp_cyc = cyc;
    if (rq.size() == 0) begin
      chk("unexpected_rsp", {30'h0, p[0], wr, resp, data}, 64'h0);
    end else begin
      rsp_exp_t e;
      e = rq.pop_front();
      chk("rsp_port", {63'h0, p[0]}, {63'h0, e.port});
      chk("rsp_kind", {63'h0, wr}, {63'h0, e.wr});
      chk("rsp_resp", {62'h0, resp}, {62'h0, e.resp});
      if (!wr) chk("rsp_rdata", {32'h0, data}, {32'h0, e.data});
      chk("other_port_quiet", {62'h0, ifc.s_bvalid[1-p], ifc.s_rvalid[1-p]}, 64'h0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int p = 0; p < 2; p++) begin
          if (ifc.s_bvalid[p] && ifc.s_bready[p]) take_rsp(p, 1'b1, ifc.s_bresp[p*2 +: 2], 32'h0);
          if (ifc.s_rvalid[p] && ifc.s_rready[p])
            take_rsp(p, 1'b0, ifc.s_rresp[p*2 +: 2], ifc.s_rdata[p*32 +: 32]);
        end
      end
    end
  end

  task automatic host_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
    int n;
    step();
    ifc.s_awvalid[p]         = 1'b1;
    ifc.s_awaddr[p*32 +: 32] = addr;
    repeat (lead) begin
      @(negedge clk);
      chk("aw_only_no_accept", {61'h0, ifc.s_awready[p], ifc.s_wready[p], busy}, 64'h0);
      @(posedge clk);
      #1;
    end
    ifc.s_wvalid[p]         = 1'b1;
    ifc.s_wdata[p*32 +: 32] = data;
    ifc.s_wstrb[p*4 +: 4]   = strb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ifc.s_awready[p] && ifc.s_wready[p]) && n < 300);
    if (n >= 300) chk("aw_w_accept_timeout", 64'h0, 64'h1);
    step();
    ifc.s_awvalid[p] = 1'b0;
    ifc.s_wvalid[p]  = 1'b0;
  endtask

  task automatic host_read(input int p, input logic [31:0] addr);
    int n;
    step();
    ifc.s_arvalid[p]         = 1'b1;
    ifc.s_araddr[p*32 +: 32] = addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.s_arready[p] && n < 300);
    if (n >= 300) chk("ar_accept_timeout", 64'h0, 64'h1);
    step();
    ifc.s_arvalid[p] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (rq.size() != 0 || eq.size() != 0); i++) @(negedge clk);
    if (rq.size() != 0 || eq.size() != 0)
      chk("drain_timeout", {32'(rq.size()), 32'(eq.size())}, 64'h0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ifc.s_awvalid = '0; ifc.s_awaddr = '0; ifc.s_wvalid = '0; ifc.s_wdata = '0;
    ifc.s_wstrb = '0; ifc.s_arvalid = '0; ifc.s_araddr = '0;
    ifc.s_bready = 2'b11; ifc.s_rready = 2'b11;
    do_reset();
    @(negedge clk);
    chk_idle("reset_outputs");
    chk("reset_rdata", ifc.s_rdata, 64'h0);

    // Port 0 write, ack two cycles after the request.
    ack_dly = 2;
    eq.push_back('{1'b1, 32'h10, 32'hA5A5_0001, 4'hF});
    rq.push_back('{1'b0, 1'b1, 2'b00, 32'h0});
    host_write(0, 32'h10, 32'hA5A5_0001, 4'hF, 0);
    drain();
    chk("grant_after_wr0", {63'h0, grant_id}, 64'h0);

    // Simultaneous reads after reset: order 0,1,0,1.
    do_reset();
    ack_dly = 0;
    for (int r = 0; r < 2; r++) begin
      eq.push_back('{1'b0, 32'h20, 32'h0, 4'h0});
      rq.push_back('{1'b0, 1'b0, 2'b00, 32'hC0DE_0020});
      eq.push_back('{1'b0, 32'h24, 32'h0, 4'h0});
      rq.push_back('{1'b1, 1'b0, 2'b00, 32'hC0DE_0024});
      fork
        host_read(0, 32'h20);
        host_read(1, 32'h24);
      join
      drain();
    end
    chk("grant_after_rr", {63'h0, grant_id}, 64'h1);

    // Read with no ack: timeout error completion.
    ack_dly = -1;
    eq.push_back('{1'b0, 32'h50, 32'h0, 4'h0});
    rq.push_back('{1'b0, 1'b0, 2'b10, 32'hDEAD_BEEF});
    host_read(0, 32'h50);
    drain();
    chk("timeout_latency", 64'(resp_cyc - req_cyc), 64'(TMO + 1));
    chk("tmo_cnt_1", {48'h0, tmo_cnt}, 64'h1);
    ack_dly = 0;

    // B held back for 10 cycles; port 1 AR must wait for the B handshake.
    ifc.s_bready[0] = 1'b0;
    eq.push_back('{1'b1, 32'h44, 32'h0BAD_F00D, 4'h5});
    rq.push_back('{1'b0, 1'b1, 2'b00, 32'h0});
    host_write(0, 32'h44, 32'h0BAD_F00D, 4'h5, 0);
    for (int i = 0; i < 50 && !ifc.s_bvalid[0]; i++) @(negedge clk);
    eq.push_back('{1'b0, 32'h48, 32'h0, 4'h0});
    rq.push_back('{1'b1, 1'b0, 2'b00, 32'hC0DE_0048});
    fork
      host_read(1, 32'h48);
    join_none
    repeat (10) begin
      @(negedge clk);
      chk("b_held", {59'h0, ifc.s_bvalid[0], ifc.s_bresp[1:0], ifc.s_arready[1], busy},
          {59'h0, 1'b1, 2'b00, 1'b0, 1'b1});
    end
    step();
    ifc.s_bready[0] = 1'b1;
    drain();

    // Reset in WAIT: transaction dropped, late ack ignored, then a normal read.
    ack_dly = 20;
    eq.push_back('{1'b0, 32'h30, 32'h0, 4'h0});
    host_read(0, 32'h30);
    step();
    step();
    @(negedge clk);
    chk("busy_in_wait", {63'h0, busy}, 64'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset_wait");
    repeat (25) @(negedge clk);
    chk("late_ack_ignored", {62'h0, busy, ifc.s_rvalid[0]}, 64'h0);
    ack_dly = 0;
    eq.push_back('{1'b0, 32'h34, 32'h0, 4'h0});
    rq.push_back('{1'b0, 1'b0, 2'b00, 32'hC0DE_0034});
    host_read(0, 32'h34);
    drain();

    // AW three cycles ahead of W, with a port 0 AR arriving alongside W: write first.
    ack_dly = 1;
    eq.push_back('{1'b1, 32'h60, 32'h1234_5678, 4'h3});
    rq.push_back('{1'b0, 1'b1, 2'b00, 32'h0});
    eq.push_back('{1'b0, 32'h64, 32'h0, 4'h0});
    rq.push_back('{1'b0, 1'b0, 2'b00, 32'hC0DE_0064});
    fork
      host_write(0, 32'h60, 32'h1234_5678, 4'h3, 3);
      begin
        repeat (3) step();
        host_read(0, 32'h64);
      end
    join
    drain();
    repeat (5) @(negedge clk);
    chk("final_idle", {63'h0, busy}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
